// File: rtl/end_screen_pkg.sv
// Shared types and default geometry for the end-screen feeder.
package end_screen_pkg;

   typedef enum logic [1:0] {IDLE, FADE_IN, SHOW} state_t;

   localparam int unsigned SCREEN_W   = 640;
   localparam int unsigned SCREEN_H   = 480;
   localparam int unsigned IMG_W_DEF  = 320;
   localparam int unsigned IMG_H_DEF  = 240;
   localparam int unsigned ADDR_W_DEF = 17;

   localparam logic [3:0] FADE_MAX = 4'd15;

endpackage

// File: rtl/end_fade_ctrl.sv
// Fade-in / blink sequencer for the end screen; advances only on frame_start.
module end_fade_ctrl
   import end_screen_pkg::*;
#(
   parameter int unsigned FADE_FRAMES  = 4,
   parameter int unsigned BLINK_FRAMES = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       game_over,
   input  logic       frame_start,
   output logic [3:0] fade_level,
   output logic       active,
   output logic       blink_off
);

   localparam int unsigned FC_W = (FADE_FRAMES  > 1) ? $clog2(FADE_FRAMES)  : 1;
   localparam int unsigned BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FADE_FRAMES - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_FRAMES - 1);

   state_t            state, state_n;
   logic [FC_W-1:0]   frame_cnt, frame_cnt_n;
   logic [BC_W-1:0]   blink_cnt, blink_cnt_n;
   logic              blink_off_n;
   logic [3:0]        fade_level_n, fade_inc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         frame_cnt  <= '0;
         blink_cnt  <= '0;
         blink_off  <= 1'b0;
         fade_level <= '0;
      end else begin
         state      <= state_n;
         frame_cnt  <= frame_cnt_n;
         blink_cnt  <= blink_cnt_n;
         blink_off  <= blink_off_n;
         fade_level <= fade_level_n;
      end
   end

   // Dropping game_over wins over a coincident frame_start.
   always_comb begin
      state_n      = state;
      frame_cnt_n  = frame_cnt;
      blink_cnt_n  = blink_cnt;
      blink_off_n  = blink_off;
      fade_level_n = fade_level;
      fade_inc     = fade_level + 4'd1;
      if (!game_over) begin
         state_n      = IDLE;
         frame_cnt_n  = '0;
         blink_cnt_n  = '0;
         blink_off_n  = 1'b0;
         fade_level_n = '0;
      end else if (frame_start) begin
         case (state)
            IDLE: begin
               state_n      = FADE_IN;
               fade_level_n = 4'd1;
               frame_cnt_n  = '0;
            end
            FADE_IN: begin
               if (frame_cnt == FC_LAST) begin
                  frame_cnt_n  = '0;
                  fade_level_n = fade_inc;
                  if (fade_inc == FADE_MAX) begin
                     state_n     = SHOW;
                     blink_cnt_n = '0;
                     blink_off_n = 1'b0;
                  end
               end else begin
                  frame_cnt_n = frame_cnt + 1'b1;
               end
            end
            SHOW: begin
               fade_level_n = FADE_MAX;
               if (blink_cnt == BC_LAST) begin
                  blink_cnt_n = '0;
                  blink_off_n = ~blink_off;
               end else begin
                  blink_cnt_n = blink_cnt + 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   assign active = (state != IDLE);

endmodule

// File: rtl/end_screen_fetch.sv
// Scan position -> half-res bitmap address, 3-stage retimed palette index gated by window/fade state.
module end_screen_fetch
   import end_screen_pkg::*;
#(
   parameter int unsigned IMG_W        = IMG_W_DEF,
   parameter int unsigned IMG_H        = IMG_H_DEF,
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned FADE_FRAMES  = 4,
   parameter int unsigned BLINK_FRAMES = 32,
   parameter int unsigned BLINK_Y0     = 176,
   parameter int unsigned BLINK_Y1     = 191
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              game_over,
   input  logic              frame_start,
   input  logic              vde,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [3:0]        rom_q,
   output logic [3:0]        index,
   output logic              index_valid,
   output logic [3:0]        fade_level,
   output logic              active
);

   localparam logic [9:0] SCR_W = 10'(IMG_W << 1);
   localparam logic [9:0] SCR_H = 10'(IMG_H << 1);

   logic              blink_off;
   logic              visible, in_band;
   logic [8:0]        bx, by;
   logic [ADDR_W-1:0] addr_c;
   logic              v1, v2;
   logic [8:0]        by1, by2;

   end_fade_ctrl #(
      .FADE_FRAMES  (FADE_FRAMES),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_ctrl (
      .clk         (Clk),
      .reset       (Reset),
      .game_over   (game_over),
      .frame_start (frame_start),
      .fade_level  (fade_level),
      .active      (active),
      .blink_off   (blink_off)
   );

   assign visible = vde && (DrawX < SCR_W) && (DrawY < SCR_H);
   assign bx      = DrawX[9:1];
   assign by      = DrawY[9:1];
   assign addr_c  = ADDR_W'(by) * ADDR_W'(IMG_W) + ADDR_W'(bx);
   assign in_band = (by2 >= 9'(BLINK_Y0)) && (by2 <= 9'(BLINK_Y1));

   // v1/by1 ride with rom_addr, v2/by2 with rom_q; stage 3 uses live fade state.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rom_addr    <= '0;
         v1          <= 1'b0;
         v2          <= 1'b0;
         by1         <= '0;
         by2         <= '0;
         index       <= '0;
         index_valid <= 1'b0;
      end else begin
         rom_addr    <= visible ? addr_c : '0;
         v1          <= visible;
         by1         <= by;
         v2          <= v1;
         by2         <= by1;
         index_valid <= v2 && active;
         index       <= (v2 && active && !(blink_off && in_band)) ? rom_q : '0;
      end
   end

endmodule

// File: tb/tb_end_screen_fetch.sv
// Randomised + directed bench for end_screen_fetch against a frame-count based reference model.
module tb_end_screen_fetch;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        game_over = 1'b0;
   logic        frame_start = 1'b0;
   logic        vde = 1'b0;
   logic [9:0]  DrawX = '0;
   logic [9:0]  DrawY = '0;
   logic [16:0] rom_addr;
   logic [3:0]  rom_q = '0;
   logic [3:0]  index;
   logic        index_valid;
   logic [3:0]  fade_level;
   logic        active;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   end_screen_fetch #(
      .IMG_W        (320),
      .IMG_H        (240),
      .ADDR_W       (17),
      .FADE_FRAMES  (4),
      .BLINK_FRAMES (32),
      .BLINK_Y0     (176),
      .BLINK_Y1     (191)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .game_over   (game_over),
      .frame_start (frame_start),
      .vde         (vde),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .rom_addr    (rom_addr),
      .rom_q       (rom_q),
      .index       (index),
      .index_valid (index_valid),
      .fade_level  (fade_level),
      .active      (active)
   );

   function automatic logic [3:0] rom_val(input int a);
      logic [3:0] s;
      s = 4'(a[3:0] + a[7:4] + a[11:8] + a[15:12] + {3'b0, a[16]});
      return s;
   endfunction

   // Synchronous ROM: data one clock after address.
   always @(posedge Clk) rom_q <= rom_val(int'(rom_addr));

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0d want=%0d", nm, $time, act, exp);
      end
   endtask

   // Reference model: fade/blink derived from the number of frames since entry.
   bit m_on = 1'b0;
   int frames = 0;
   bit rst_h[2] = '{1'b1, 1'b1};
   bit vis_h[2] = '{1'b0, 1'b0};
   int addr_h[2] = '{0, 0};
   int by_h[2] = '{0, 0};
   int e_addr, e_index, e_fade;
   bit e_valid, e_active, ready = 1'b0;
   bit vis_now, ap, bp;
   int a_now;

   always @(posedge Clk) begin
      ap      = m_on;
      bp      = m_on && frames >= 56 && (((frames - 56) / 32) % 2 == 1);
      vis_now = vde && DrawX < 640 && DrawY < 480;
      a_now   = (int'(DrawY) / 2) * 320 + int'(DrawX) / 2;
      e_addr  = (Reset || !vis_now) ? 0 : a_now;
      e_valid = !Reset && !rst_h[0] && !rst_h[1] && vis_h[1] && ap;
      e_index = (e_valid && !(bp && by_h[1] >= 176 && by_h[1] <= 191)) ? int'(rom_val(addr_h[1])) : 0;
      if (Reset || !game_over) begin
         m_on = 1'b0;
         frames = 0;
      end else if (frame_start) begin
         if (!m_on) begin
            m_on = 1'b1;
            frames = 0;
         end else begin
            frames++;
         end
      end
      e_active = m_on;
      e_fade   = !m_on ? 0 : (frames >= 56 ? 15 : 1 + frames / 4);
      rst_h[1] = rst_h[0];  rst_h[0] = Reset;
      vis_h[1] = vis_h[0];  vis_h[0] = vis_now;
      addr_h[1] = addr_h[0]; addr_h[0] = a_now;
      by_h[1] = by_h[0];    by_h[0] = int'(DrawY) / 2;
      ready = 1'b1;
   end

   always @(negedge Clk) begin
      if (ready) begin
         chk("rom_addr", int'(rom_addr), e_addr);
         chk("index", int'(index), e_index);
         chk("index_valid", int'(index_valid), int'(e_valid));
         chk("fade_level", int'(fade_level), e_fade);
         chk("active", int'(active), int'(e_active));
      end
   end

   task automatic drive(input int x, input int y, input bit v, input bit fs);
      DrawX = 10'(x);
      DrawY = 10'(y);
      vde = v;
      frame_start = fs;
      @(negedge Clk);
   endtask

   task automatic pulse();
      drive(0, 0, 1'b0, 1'b1);
      drive(0, 0, 1'b0, 1'b0);
   endtask

   task automatic rand_cycle(input bit fs);
      int y;
      if ($urandom_range(0, 9) < 4) y = $urandom_range(340, 400);
      else y = $urandom_range(0, 524);
      drive($urandom_range(0, 799), y, ($urandom_range(0, 9) < 8), fs);
   endtask

   initial begin
      @(negedge Clk);
      // reset and idle behaviour
      Reset = 1'b1;
      drive(0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      chk("rst_rom_addr", int'(rom_addr), 0);
      chk("rst_index", int'(index), 0);
      chk("rst_valid", int'(index_valid), 0);
      chk("rst_fade", int'(fade_level), 0);
      chk("rst_active", int'(active), 0);
      Reset = 1'b0;
      rand_cycle(1'b1);
      for (int i = 0; i < 40; i++) begin
         rand_cycle(1'b0);
         chk("idle_valid", int'(index_valid), 0);
      end

      // fade-in
      game_over = 1'b1;
      drive(0, 0, 1'b0, 1'b1);
      chk("entry_active", int'(active), 1);
      chk("entry_fade", int'(fade_level), 1);
      drive(0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) pulse();
      chk("fade_step2", int'(fade_level), 2);
      for (int i = 0; i < 52; i++) pulse();
      chk("fade_full", int'(fade_level), 15);

      // address and 3-cycle latency
      drive(101, 33, 1'b1, 1'b0);
      chk("addr_5170", int'(rom_addr), 5170);
      drive(0, 0, 1'b0, 1'b0);
      chk("lat_not_early", int'(index_valid), 0);
      drive(0, 0, 1'b0, 1'b0);
      chk("idx_5170", int'(index), 10);
      chk("val_5170", int'(index_valid), 1);

      // blink band
      for (int i = 0; i < 32; i++) pulse();
      drive(101, 360, 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      chk("blink_idx", int'(index), 0);
      chk("blink_val", int'(index_valid), 1);
      drive(101, 400, 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      chk("below_band_idx", int'(index), 14);

      // invisible pixels
      drive(101, 33, 1'b0, 1'b0);
      chk("vde0_addr", int'(rom_addr), 0);
      drive(700, 33, 1'b1, 1'b0);
      chk("x700_addr", int'(rom_addr), 0);
      drive(0, 0, 1'b0, 1'b0);
      chk("vde0_valid", int'(index_valid), 0);
      drive(0, 0, 1'b0, 1'b0);
      chk("x700_valid", int'(index_valid), 0);

      // exit mid-fade, then reset mid-pipeline
      game_over = 1'b0;
      drive(0, 0, 1'b0, 1'b0);
      game_over = 1'b1;
      pulse();
      for (int i = 0; i < 20; i++) pulse();
      chk("fade_lvl6", int'(fade_level), 6);
      game_over = 1'b0;
      drive(0, 0, 1'b0, 1'b1);
      chk("drop_fade", int'(fade_level), 0);
      chk("drop_active", int'(active), 0);
      game_over = 1'b1;
      pulse();
      drive(101, 33, 1'b1, 1'b0);
      drive(101, 33, 1'b1, 1'b0);
      Reset = 1'b1;
      drive(101, 33, 1'b1, 1'b0);
      chk("midrst_valid", int'(index_valid), 0);
      chk("midrst_fade", int'(fade_level), 0);
      chk("midrst_addr", int'(rom_addr), 0);
      Reset = 1'b0;
      drive(0, 0, 1'b0, 1'b0);
      chk("postrst_valid", int'(index_valid), 0);

      // randomised frames
      for (int f = 0; f < 200; f++) begin
         rand_cycle(1'b1);
         for (int c = 1; c < 30; c++) begin
            if (f == 130 && c == 10) game_over = 1'b0;
            if (f == 130 && c == 13) game_over = 1'b1;
            Reset = (f == 170 && c == 5);
            rand_cycle(1'b0);
         end
      end
      Reset = 1'b0;
      drive(0, 0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
